// File: rtl/alu_seq_pkg.sv
// Shared opcode (card) codes, CMP flag positions and FSM encodings for alu_seq.
// The MUL card is only executed when ALU_MUL_EN is defined.
package alu_seq_pkg;

  localparam int CARD_W = 5;
  typedef logic [CARD_W-1:0] card_t;

  localparam card_t CARD_ADD   = 5'd0;
  localparam card_t CARD_ASUBB = 5'd1;
  localparam card_t CARD_AND   = 5'd2;
  localparam card_t CARD_OR    = 5'd3;
  localparam card_t CARD_XOR   = 5'd4;
  localparam card_t CARD_MOVZ  = 5'd5;
  localparam card_t CARD_SIL   = 5'd6;
  localparam card_t CARD_CMP   = 5'd7;
  localparam card_t CARD_MUL   = 5'd8;
  localparam card_t CARD_SRL   = 5'd9;
  localparam card_t CARD_SRA   = 5'd10;

  localparam int CMP_EQ    = 0;
  localparam int CMP_SLT   = 1;
  localparam int CMP_ULT   = 2;
  localparam int CMP_SLE   = 3;
  localparam int CMP_ULE   = 4;
  localparam int CMP_FLAGS = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Low half holds the flags, high half their complements.
  function automatic logic [2*CMP_FLAGS-1:0] cmp_word(input logic eq, input logic slt,
                                                      input logic ult);
    logic [CMP_FLAGS-1:0] f;
    f          = '0;
    f[CMP_EQ]  = eq;
    f[CMP_SLT] = slt;
    f[CMP_ULT] = ult;
    f[CMP_SLE] = slt | eq;
    f[CMP_ULE] = ult | eq;
    return {~f, f};
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, W cycles busy.
// Only instantiated by alu_seq when ALU_MUL_EN is defined.
module alu_mul_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  acc_reg;
  logic [W-1:0]  mcand_reg;
  logic [W-1:0]  mplier_reg;
  logic [CW-1:0] count_reg;
  logic          busy_reg;
  logic          done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        acc_reg    <= '0;
        mcand_reg  <= a;
        mplier_reg <= b;
        count_reg  <= '0;
        busy_reg   <= 1'b1;
      end else if (busy_reg) begin
        // Bits shifted past W are dropped, so the product wraps modulo 2^W.
        acc_reg    <= acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        count_reg  <= count_reg + 1'b1;
        if (count_reg == LAST) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/alu_seq.sv
// Registered EX-stage ALU with valid/ready handshakes on both sides.
// Define ALU_MUL_EN to add the iterative MUL; otherwise MUL behaves as an unknown card.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W    = 32,
  parameter int SA_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CARD_W-1:0] card,
  input  logic [W-1:0]      rs_value,
  input  logic [W-1:0]      rt_value,
  input  logic [SA_W-1:0]   sa,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      rd_value,
  output logic              en_reg_write
);

  logic                     out_valid_reg;
  logic [W-1:0]             rd_value_reg;
  logic                     en_reg_write_reg;
  logic [W-1:0]             op_result;
  logic                     op_wen;
  logic [2*CMP_FLAGS-1:0]   cmp_bits;
  logic                     idle;
  logic                     accept;
  logic                     accept_mul;
  logic                     mul_done;
  logic [W-1:0]             mul_product;

  assign cmp_bits = cmp_word(rs_value == rt_value,
                             $signed(rs_value) < $signed(rt_value),
                             rs_value < rt_value);

  always_comb begin
    op_result = '0;
    op_wen    = 1'b0;
    case (card)
      CARD_ADD:   begin op_result = rs_value + rt_value;             op_wen = 1'b1; end
      CARD_ASUBB: begin op_result = rs_value - rt_value;             op_wen = 1'b1; end
      CARD_AND:   begin op_result = rs_value & rt_value;             op_wen = 1'b1; end
      CARD_OR:    begin op_result = rs_value | rt_value;             op_wen = 1'b1; end
      CARD_XOR:   begin op_result = rs_value ^ rt_value;             op_wen = 1'b1; end
      CARD_SIL:   begin op_result = rt_value << sa;                  op_wen = 1'b1; end
      CARD_SRL:   begin op_result = rt_value >> sa;                  op_wen = 1'b1; end
      CARD_SRA:   begin op_result = $unsigned($signed(rt_value) >>> sa); op_wen = 1'b1; end
      CARD_CMP:   begin op_result = W'(cmp_bits);                    op_wen = 1'b1; end
      CARD_MOVZ: begin
        if (rt_value == '0) begin
          op_result = rs_value;
          op_wen    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign in_ready = idle & (~out_valid_reg | out_ready);
  assign accept   = in_valid & in_ready;

`ifdef ALU_MUL_EN
  state_t state_reg;
  logic   mul_busy;

  assign idle       = (state_reg == ST_IDLE) & ~mul_busy;
  assign accept_mul = accept & (card == CARD_MUL);

  alu_mul_iter #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept_mul),
    .a       (rs_value),
    .b       (rt_value),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign idle        = 1'b1;
  assign accept_mul  = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef ALU_MUL_EN
      state_reg <= ST_IDLE;
`endif
      out_valid_reg    <= 1'b0;
      rd_value_reg     <= '0;
      en_reg_write_reg <= 1'b0;
    end else begin
`ifdef ALU_MUL_EN
      if (accept_mul) begin
        state_reg <= ST_MUL;
      end else if (mul_done) begin
        state_reg <= ST_IDLE;
      end
`endif
      if (mul_done) begin
        out_valid_reg    <= 1'b1;
        rd_value_reg     <= mul_product;
        en_reg_write_reg <= 1'b1;
      end else if (accept && !accept_mul) begin
        out_valid_reg    <= 1'b1;
        rd_value_reg     <= op_result;
        en_reg_write_reg <= op_wen;
      end else if (accept_mul || out_ready) begin
        // Accepting MUL implies the output slot is free or being drained now.
        out_valid_reg    <= 1'b0;
        rd_value_reg     <= '0;
        en_reg_write_reg <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign rd_value     = rd_value_reg;
  assign en_reg_write = en_reg_write_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a result scoreboard; MUL expectations follow ALU_MUL_EN.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W    = 32;
  localparam int SA_W = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0]      card = '0;
  logic [W-1:0]    rs_value = '0;
  logic [W-1:0]    rt_value = '0;
  logic [SA_W-1:0] sa = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [W-1:0]    rd_value;
  logic            en_reg_write;

  int checks = 0;
  int errors = 0;
  int next_id = 0;

  typedef struct {
    logic [W-1:0] rd;
    logic         wen;
    int           id;
  } exp_t;

  exp_t sb[$];

  logic [4:0] op_list [10] = '{CARD_ADD, CARD_ASUBB, CARD_AND, CARD_OR, CARD_XOR,
                               CARD_MOVZ, CARD_SIL, CARD_SRL, CARD_SRA, CARD_CMP};

  alu_seq #(.W(W), .SA_W(SA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .card         (card),
    .rs_value     (rs_value),
    .rt_value     (rt_value),
    .sa           (sa),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .rd_value     (rd_value),
    .en_reg_write (en_reg_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] c, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [SA_W-1:0] s);
    exp_t e;
    e.rd  = '0;
    e.wen = 1'b0;
    e.id  = 0;
    case (c)
      CARD_ADD:   begin e.rd = a + b;  e.wen = 1'b1; end
      CARD_ASUBB: begin e.rd = a - b;  e.wen = 1'b1; end
      CARD_AND:   begin e.rd = a & b;  e.wen = 1'b1; end
      CARD_OR:    begin e.rd = a | b;  e.wen = 1'b1; end
      CARD_XOR:   begin e.rd = a ^ b;  e.wen = 1'b1; end
      CARD_SIL:   begin e.rd = b << s; e.wen = 1'b1; end
      CARD_SRL:   begin e.rd = b >> s; e.wen = 1'b1; end
      CARD_SRA:   begin e.rd = $unsigned($signed(b) >>> s); e.wen = 1'b1; end
      CARD_MOVZ:  begin e.rd = (b == 0) ? a : '0; e.wen = (b == 0); end
      CARD_CMP: begin
        e.rd[0]   = (a == b);
        e.rd[1]   = ($signed(a) < $signed(b));
        e.rd[2]   = (a < b);
        e.rd[3]   = ($signed(a) <= $signed(b));
        e.rd[4]   = (a <= b);
        e.rd[9:5] = ~e.rd[4:0];
        e.wen     = 1'b1;
      end
`ifdef ALU_MUL_EN
      CARD_MUL:   begin e.rd = a * b; e.wen = 1'b1; end
`endif
      default: ;
    endcase
    return e;
  endfunction

  // Call shortly after a rising edge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SA_W-1:0] s, input bit chk_lat);
    int   n;
    exp_t e;
    n = 0;
    #1;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n == 100) check("issue_timeout", 32'(in_ready), 32'd1);
    card     = c;
    rs_value = a;
    rt_value = b;
    sa       = s;
    in_valid = 1'b1;
    e        = model(c, a, b, s);
    e.id     = next_id;
    next_id++;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rs_value = $urandom;
    rt_value = $urandom;
    if (chk_lat) check($sformatf("latency_%0d", e.id), 32'(out_valid), 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        $display("txn %0d rd=%h wen=%b", e.id, rd_value, en_reg_write);
        check($sformatf("rd_%0d", e.id), rd_value, e.rd);
        check($sformatf("wen_%0d", e.id), 32'(en_reg_write), 32'(e.wen));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  cycles;
    bit  ir_low;
    bit  saw;
    logic [4:0]   c;
    logic [W-1:0] b;

    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rd_value", rd_value, 32'd0);
    check("rst_en_reg_write", 32'(en_reg_write), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed single-cycle operations
    issue(CARD_ADD,   32'hFFFF_FFFF, 32'h0000_0002, 5'd0,  1);
    issue(CARD_ASUBB, 32'h0000_0005, 32'h0000_0007, 5'd0,  1);
    issue(CARD_AND,   32'hF0F0_1234, 32'h0FF0_FF00, 5'd0,  1);
    issue(CARD_OR,    32'hA000_0001, 32'h0500_0010, 5'd0,  1);
    issue(CARD_XOR,   32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  1);
    issue(CARD_SIL,   32'h1234_5678, 32'h0000_0001, 5'd31, 1);
    issue(CARD_SRL,   32'h0000_0000, 32'h8000_0000, 5'd4,  1);
    issue(CARD_SRA,   32'h0000_0000, 32'h8000_0000, 5'd4,  1);
    issue(CARD_SRA,   32'h0000_0000, 32'h7FFF_FFFF, 5'd31, 1);
    issue(CARD_CMP,   32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  1);
    issue(CARD_CMP,   32'h0000_0005, 32'h0000_0005, 5'd0,  1);
    issue(CARD_CMP,   32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  1);
    issue(CARD_MOVZ,  32'hDEAD_BEEF, 32'h0000_0000, 5'd0,  1);
    issue(CARD_MOVZ,  32'hDEAD_BEEF, 32'h0000_0005, 5'd0,  1);
    issue(5'd31,      32'h1111_1111, 32'h2222_2222, 5'd3,  1);
`ifndef ALU_MUL_EN
    issue(CARD_MUL,   32'h0001_2345, 32'h0000_0100, 5'd0,  1);
`endif

    // Back-to-back random traffic
    for (int i = 0; i < 12; i++) begin
      c = op_list[$urandom_range(0, 9)];
      b = (c == CARD_MOVZ && $urandom_range(0, 1) == 1) ? '0 : W'($urandom);
      issue(c, W'($urandom), b, SA_W'($urandom), 1);
    end

    // Back-pressure: result held, queued op taken on the releasing edge
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(CARD_XOR, 32'h1111_0000, 32'h0000_2222, 5'd0, 1);
    card     = CARD_ADD;
    rs_value = 32'd100;
    rt_value = 32'd23;
    sa       = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_%0d", i), rd_value, 32'h1111_2222);
      check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    begin
      exp_t e;
      e    = model(CARD_ADD, 32'd100, 32'd23, '0);
      e.id = next_id;
      next_id++;
      sb.push_back(e);
    end
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_queued_valid", 32'(out_valid), 32'd1);
    check("bp_queued_rd", rd_value, 32'd123);

`ifdef ALU_MUL_EN
    // Iterative multiply latency and busy window
    issue(CARD_MUL, 32'h0001_2345, 32'h0000_0100, 5'd0, 0);
    cycles = 0;
    ir_low = 1'b1;
    while (!out_valid && cycles < 100) begin
      if (in_ready) ir_low = 1'b0;
      @(posedge clk);
      #1;
      cycles++;
    end
    check("mul_latency", 32'(cycles), 32'(W + 1));
    check("mul_in_ready_low", 32'(ir_low), 32'd1);
    check("mul_rd", rd_value, 32'h0123_4500);
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply
    issue(CARD_MUL, 32'h0000_0003, 32'h0000_0007, 5'd0, 0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mulrst_valid", 32'(out_valid), 32'd0);
    sb.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (W + 5) begin
      @(posedge clk);
      #1;
      if (out_valid) saw = 1'b1;
    end
    check("mulrst_no_result", 32'(saw), 32'd0);
`endif

    // Asynchronous reset while a result is held
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(CARD_OR, 32'h0000_00F0, 32'h0000_000F, 5'd0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_rd_value", rd_value, 32'd0);
    check("arst_en_reg_write", 32'(en_reg_write), 32'd0);
    sb.delete();
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    issue(CARD_ADD, 32'h0000_0001, 32'h0000_0002, 5'd0, 1);

    // Drain the scoreboard
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
